// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard/redirect controller.
package pipeline_ctrl_pkg;

  localparam int unsigned CNT_W               = 4;
  localparam int unsigned MULT_CYCLES_DEFAULT = 5;
  localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_EXC = 2'b01;
  localparam logic [1:0] PC_SEL_EPC = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } ctrl_state_e;

  // Countdown load value for a newly issued MDU operation.
  function automatic logic [CNT_W-1:0] mdu_load_value(input logic is_div,
                                                      input int unsigned mult_cycles,
                                                      input int unsigned div_cycles);
    return is_div ? CNT_W'(div_cycles) : CNT_W'(mult_cycles);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control/status bundle between the pipeline datapath and pipeline_ctrl.
interface pipeline_ctrl_if;
  logic       d_stall_req;
  logic       d_is_mdu;
  logic       mdu_start;
  logic       mdu_is_div;
  logic       exc_req;
  logic       eret_req;
  logic       pc_en;
  logic       d_en;
  logic       d_clear;
  logic       e_clear;
  logic       m_clear;
  logic [1:0] pc_sel;
  logic       mdu_busy;

  // Datapath side: raises hazards and events, consumes enables/clears.
  modport master (
    output d_stall_req, d_is_mdu, mdu_start, mdu_is_div, exc_req, eret_req,
    input  pc_en, d_en, d_clear, e_clear, m_clear, pc_sel, mdu_busy
  );

  // Controller side.
  modport slave (
    input  d_stall_req, d_is_mdu, mdu_start, mdu_is_div, exc_req, eret_req,
    output pc_en, d_en, d_clear, e_clear, m_clear, pc_sel, mdu_busy
  );
endinterface

// File: rtl/pipeline_ctrl_mdu_busy_timer.sv
// MDU busy countdown: loads on an accepted start, counts down to zero.
// kill suppresses a new start but never cancels a running countdown.
module mdu_busy_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic kill,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: decrement while running, otherwise accept an unkilled start.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (start && !kill) begin
      cnt_d = mdu_load_value(is_div, MULT_CYCLES, DIV_CYCLES);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/redirect controller with MDU busy tracking.
// Optional stall_cycles performance counter: define PIPELINE_CTRL_STALL_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  pipeline_ctrl_if.slave bus
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cycles
`endif
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  logic       mdu_busy;
  logic       stall;
  logic       stall_hold;
  logic       pc_en;
  logic       d_en;
  logic       d_clear;
  logic       e_clear;
  logic       m_clear;
  logic [1:0] pc_sel;

  mdu_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (bus.mdu_start),
    .is_div (bus.mdu_is_div),
    .kill   (bus.exc_req),
    .busy   (mdu_busy)
  );

  assign stall = bus.d_stall_req | (bus.d_is_mdu & (mdu_busy | bus.mdu_start));

  // Next state and combinational controls; reset > exc > eret > stall.
  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b1;
    d_en       = 1'b1;
    d_clear    = 1'b0;
    e_clear    = 1'b0;
    m_clear    = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    stall_hold = 1'b0;
    if (reset) begin
      d_clear = 1'b1;
      e_clear = 1'b1;
      m_clear = 1'b1;
      state_d = ST_RUN;
    end else if (bus.exc_req) begin
      pc_sel  = PC_SEL_EXC;
      d_clear = 1'b1;
      e_clear = 1'b1;
      m_clear = 1'b1;
      state_d = ST_REDIRECT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.eret_req) begin
            pc_sel  = PC_SEL_EPC;
            d_clear = 1'b1;
            e_clear = 1'b1;
            m_clear = 1'b1;
            state_d = ST_REDIRECT;
          end else if (stall) begin
            pc_en      = 1'b0;
            d_en       = 1'b0;
            e_clear    = 1'b1;
            stall_hold = 1'b1;
          end
        end
        ST_REDIRECT: begin
          // Squash the wrong-path fetch; eret and stall are ignored here.
          d_clear = 1'b1;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.pc_en    = pc_en;
  assign bus.d_en     = d_en;
  assign bus.d_clear  = d_clear;
  assign bus.e_clear  = e_clear;
  assign bus.m_clear  = m_clear;
  assign bus.pc_sel   = pc_sel;
  assign bus.mdu_busy = mdu_busy;

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  // Count cycles spent holding the front end for a hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_hold) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Output vector packing used by step():
// {pc_en, d_en, d_clear, e_clear, m_clear, pc_sel[1:0], mdu_busy}
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus();

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  pipeline_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;
  int exp_stalls = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic stall_req, input logic is_mdu, input logic start,
                       input logic is_div, input logic exc, input logic eret);
    bus.d_stall_req = stall_req;
    bus.d_is_mdu    = is_mdu;
    bus.mdu_start   = start;
    bus.mdu_is_div  = is_div;
    bus.exc_req     = exc;
    bus.eret_req    = eret;
  endtask

  // Check this cycle's outputs mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic [7:0] exp);
    logic in_reset;
    #2;
    check_eq(tag, {24'd0, bus.pc_en, bus.d_en, bus.d_clear, bus.e_clear, bus.m_clear,
                   bus.pc_sel, bus.mdu_busy}, {24'd0, exp});
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    check_eq({tag, "_stall_cycles"}, stall_cycles, 32'(exp_stalls));
`endif
    in_reset = reset;
    @(posedge clk);
    #1;
    if (in_reset) exp_stalls = 0;
    else if (exp[7:1] == 7'b00_010_00) exp_stalls++;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("reset_cycle", 8'b11_111_00_0);
    reset = 1'b0;
    step("idle", 8'b11_000_00_0);

    // mult with dependent MDU instruction held in D
    drive(0, 1, 1, 0, 0, 0);
    step("mul_c0", 8'b00_010_00_0);
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step($sformatf("mul_c%0d", i), 8'b00_010_00_1);
    step("mul_c6", 8'b11_000_00_0);

    // div, dependent instruction arrives after issue, retry start ignored
    drive(0, 0, 1, 1, 0, 0);
    step("div_c0", 8'b11_000_00_0);
    for (int i = 1; i <= 10; i++) begin
      drive(0, 1, (i == 3), 0, 0, 0);
      step($sformatf("div_c%0d", i), 8'b00_010_00_1);
    end
    step("div_c11", 8'b11_000_00_0);

    // exception overrides a data stall, then redirect bubble
    drive(1, 0, 0, 0, 1, 0);
    step("exc_c0", 8'b11_111_01_0);
    drive(1, 0, 0, 0, 0, 0);
    step("exc_redirect", 8'b11_100_00_0);
    step("exc_run_stall", 8'b00_010_00_0);
    drive(0, 0, 0, 0, 0, 0);
    step("exc_idle", 8'b11_000_00_0);

    // exc wins over eret; eret in REDIRECT ignored; eret in RUN redirects
    drive(0, 0, 0, 0, 1, 1);
    step("exc_eret", 8'b11_111_01_0);
    drive(0, 0, 0, 0, 0, 1);
    step("eret_in_redirect", 8'b11_100_00_0);
    step("eret_run", 8'b11_111_10_0);
    drive(0, 0, 0, 0, 0, 0);
    step("eret_redirect", 8'b11_100_00_0);
    step("eret_idle", 8'b11_000_00_0);

    // back-to-back exceptions keep REDIRECT
    drive(0, 0, 0, 0, 1, 0);
    step("exc2_c0", 8'b11_111_01_0);
    step("exc2_c1", 8'b11_111_01_0);
    drive(0, 0, 0, 0, 0, 0);
    step("exc2_redirect", 8'b11_100_00_0);
    step("exc2_idle", 8'b11_000_00_0);

    // start in the exception cycle is dropped
    drive(0, 0, 1, 1, 1, 0);
    step("exc_start", 8'b11_111_01_0);
    drive(0, 0, 0, 0, 0, 0);
    step("exc_start_redir", 8'b11_100_00_0);
    step("exc_start_idle", 8'b11_000_00_0);

    // exception during a running div does not cancel it
    drive(0, 0, 1, 1, 0, 0);
    step("divx_c0", 8'b11_000_00_0);
    drive(0, 0, 0, 0, 0, 0);
    step("divx_c1", 8'b11_000_00_1);
    drive(0, 0, 0, 0, 1, 0);
    step("divx_c2_exc", 8'b11_111_01_1);
    drive(0, 0, 0, 0, 0, 0);
    step("divx_c3_redir", 8'b11_100_00_1);
    for (int i = 4; i <= 10; i++) step($sformatf("divx_c%0d", i), 8'b11_000_00_1);
    step("divx_c11", 8'b11_000_00_0);

    // reset aborts a div countdown
    drive(0, 0, 1, 1, 0, 0);
    step("divr_c0", 8'b11_000_00_0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step($sformatf("divr_c%0d", i), 8'b11_000_00_1);
    reset = 1'b1;
    step("divr_reset", 8'b11_111_00_1);
    reset = 1'b0;
    step("divr_after", 8'b11_000_00_0);

    // reset aborts REDIRECT
    drive(0, 0, 0, 0, 1, 0);
    step("rdr_exc", 8'b11_111_01_0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step("rdr_reset", 8'b11_111_00_0);
    reset = 1'b0;
    step("rdr_after", 8'b11_000_00_0);

    // seven plain data stalls, then reset
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step($sformatf("st_c%0d", i), 8'b00_010_00_0);
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    check_eq("stall_cycles_7", stall_cycles, 32'd7);
`endif
    reset = 1'b1;
    step("st_reset", 8'b11_111_00_0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step("st_after", 8'b11_000_00_0);
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    check_eq("stall_cycles_0", stall_cycles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
